// File: rtl/mem_debug_reader_if.sv
// Debug read port between mem_debug_reader and the dual-port memory.
// The reader drives the address; the memory answers combinationally in the same cycle.
interface mem_debug_reader_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_data;

  modport master (
    output addr,
    input  mem_data
  );

  modport slave (
    input  addr,
    output mem_data
  );
endinterface

// File: rtl/mem_debug_reader.sv
// Read-only debug initiator: a button-driven cursor viewer plus a range checksum engine
// sharing one asynchronous debug read port of the data/instruction memory.
module mem_debug_reader #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          sum_start,
  input  logic [AW-1:0] sum_base,
  input  logic [AW:0]   sum_len,
  mem_debug_reader_if.master dbg,
  output logic [AW-1:0] view_addr,
  output logic [DW-1:0] view_data,
  output logic          busy,
  output logic          sum_done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] cursor_r;
  logic [AW-1:0] ptr_r;
  logic [AW:0]   remaining_r;
  logic [DW-1:0] acc_r;
  logic [DW-1:0] view_data_r;
  logic [DW-1:0] checksum_r;
  logic          busy_r;
  logic          sum_done_r;
  logic          inc_q_r;
  logic          dec_q_r;

  logic          inc_p_s;
  logic          dec_p_s;
  logic [AW-1:0] cursor_next_s;

  // Rising-edge detection on the button levels and the resulting cursor step.
  always_comb begin
    inc_p_s       = inc & ~inc_q_r;
    dec_p_s       = dec & ~dec_q_r;
    cursor_next_s = cursor_r;
    if (inc_p_s && !dec_p_s) begin
      cursor_next_s = cursor_r + ADDR_ONE;
    end else if (dec_p_s && !inc_p_s) begin
      cursor_next_s = cursor_r - ADDR_ONE;
    end else begin
      cursor_next_s = cursor_r;
    end
  end

  // The checksum pointer owns the read port only while summing; otherwise the cursor does.
  assign dbg.addr = (state_r == ST_SUM) ? ptr_r : cursor_r;

  // Control FSM together with all its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cursor_r    <= {AW{1'b0}};
      ptr_r       <= {AW{1'b0}};
      remaining_r <= LEN_ZERO;
      acc_r       <= {DW{1'b0}};
      view_data_r <= {DW{1'b0}};
      checksum_r  <= {DW{1'b0}};
      busy_r      <= 1'b0;
      sum_done_r  <= 1'b0;
      inc_q_r     <= 1'b0;
      dec_q_r     <= 1'b0;
    end else begin
      inc_q_r <= inc;
      dec_q_r <= dec;
      case (state_r)
        ST_IDLE: begin
          cursor_r    <= cursor_next_s;
          view_data_r <= dbg.mem_data;
          sum_done_r  <= 1'b0;
          if (sum_start) begin
            acc_r <= {DW{1'b0}};
            if (sum_len == LEN_ZERO) begin
              state_r    <= ST_DONE;
              busy_r     <= 1'b0;
              sum_done_r <= 1'b1;
            end else begin
              ptr_r       <= sum_base;
              remaining_r <= sum_len;
              state_r     <= ST_SUM;
              busy_r      <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SUM: begin
          // Cursor and view are frozen here; button edges are consumed and dropped.
          acc_r       <= acc_r + dbg.mem_data;
          ptr_r       <= ptr_r + ADDR_ONE;
          remaining_r <= remaining_r - LEN_ONE;
          if (remaining_r == LEN_ONE) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            sum_done_r <= 1'b1;
          end else begin
            state_r    <= ST_SUM;
            busy_r     <= 1'b1;
            sum_done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          checksum_r  <= acc_r;
          view_data_r <= dbg.mem_data;
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          sum_done_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          sum_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign view_addr = cursor_r;
  assign view_data = view_data_r;
  assign busy      = busy_r;
  assign sum_done  = sum_done_r;
  assign checksum  = checksum_r;

endmodule

// File: tb/tb_mem_debug_reader.sv
// Self-checking bench for mem_debug_reader: randomized cursor and checksum scenarios
// compared against a simple array/arithmetic reference model.
module tb_mem_debug_reader;

  logic        clk;
  logic        rst;
  logic        inc;
  logic        dec;
  logic        sum_start;
  logic [7:0]  sum_base;
  logic [8:0]  sum_len;
  logic [7:0]  view_addr;
  logic [31:0] view_data;
  logic        busy;
  logic        sum_done;
  logic [31:0] checksum;

  logic [31:0] mem [256];
  int total;
  int bad;
  int cur;
  logic [31:0] last_sum;

  mem_debug_reader_if #(.AW(8), .DW(32)) bus ();

  assign bus.mem_data = mem[bus.addr];

  mem_debug_reader #(.AW(8), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .dec       (dec),
    .sum_start (sum_start),
    .sum_base  (sum_base),
    .sum_len   (sum_len),
    .dbg       (bus.master),
    .view_addr (view_addr),
    .view_data (view_data),
    .busy      (busy),
    .sum_done  (sum_done),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_sum(input int base, input int len);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < len; i++) s = s + mem[(base + i) % 256];
    return s;
  endfunction

  task automatic check_view(input string name);
    logic [7:0] ea;
    ea = cur[7:0];
    total++;
    if (view_addr !== ea) begin
      bad++;
      $display("FAIL %s view_addr got=%h exp=%h", name, view_addr, ea);
    end
    total++;
    if (bus.addr !== ea) begin
      bad++;
      $display("FAIL %s addr got=%h exp=%h", name, bus.addr, ea);
    end
  endtask

  task automatic pulse(input bit up);
    if (up) inc = 1'b1; else dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    cur = up ? (cur + 1) % 256 : (cur + 255) % 256;
    check_view(up ? "inc_step" : "dec_step");
    tick();
    total++;
    if (view_data !== mem[cur]) begin
      bad++;
      $display("FAIL view_follow got=%h exp=%h", view_data, mem[cur]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h12345678;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur = 0;
    check_view("reset");
    total++;
    if (view_data !== 32'd0) begin bad++; $display("FAIL reset_view got=%h exp=0", view_data); end
    total++;
    if (busy !== 1'b0 || sum_done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b exp=0", busy, sum_done); end
    total++;
    if (checksum !== 32'd0) begin bad++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
    tick();
    total++;
    if (view_data !== 32'h12345678) begin bad++; $display("FAIL reset_read got=%h exp=12345678", view_data); end
  endtask

  task automatic test_cursor_wrap();
    for (int i = 0; i < 3; i++) pulse(1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1);
    inc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    inc = 1'b0;
    tick();
    cur = (cur + 1) % 256;
    check_view("held_inc");
    inc = 1'b1;
    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
    check_view("inc_dec_same");
  endtask

  task automatic test_cursor_random();
    bit pi, pd, ni, nd;
    pi = 1'b0;
    pd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ni = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      inc = ni;
      dec = nd;
      tick();
      if (ni && !pi && !(nd && !pd)) cur = (cur + 1) % 256;
      else if (nd && !pd && !(ni && !pi)) cur = (cur + 255) % 256;
      pi = ni;
      pd = nd;
      check_view("rand_cursor");
    end
    inc = 1'b0;
    dec = 1'b0;
    tick();
    tick();
    total++;
    if (view_data !== mem[cur]) begin bad++; $display("FAIL rand_view got=%h exp=%h", view_data, mem[cur]); end
  endtask

  task automatic run_sum(input int base, input int len, input bit inc_during, input bit start_during);
    logic [31:0] exp;
    logic [7:0] ea;
    exp = ref_sum(base, len);
    sum_base = 8'(base);
    sum_len = 9'(len);
    sum_start = 1'b1;
    tick();
    sum_start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      ea = 8'((base + c - 1) % 256);
      total++;
      if (busy !== 1'b1 || sum_done !== 1'b0) begin bad++; $display("FAIL sum_busy c=%0d busy=%b done=%b exp=1/0", c, busy, sum_done); end
      total++;
      if (bus.addr !== ea) begin bad++; $display("FAIL sum_addr c=%0d got=%h exp=%h", c, bus.addr, ea); end
      inc = inc_during && (c == 2);
      sum_start = start_during && (c == 3) && (len >= 5);
      tick();
      inc = 1'b0;
      sum_start = 1'b0;
    end
    total++;
    if (sum_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL sum_done_pulse len=%0d done=%b busy=%b exp=1/0", len, sum_done, busy); end
    check_view("done_addr");
    tick();
    total++;
    if (sum_done !== 1'b0) begin bad++; $display("FAIL sum_done_width got=%b exp=0", sum_done); end
    total++;
    if (checksum !== exp) begin bad++; $display("FAIL checksum base=%0d len=%0d got=%h exp=%h", base, len, checksum, exp); end
    tick();
    tick();
    total++;
    if (checksum !== exp || busy !== 1'b0) begin bad++; $display("FAIL checksum_hold got=%h busy=%b exp=%h", checksum, busy, exp); end
    check_view("after_sum");
    total++;
    if (view_data !== mem[cur]) begin bad++; $display("FAIL after_sum_view got=%h exp=%h", view_data, mem[cur]); end
    last_sum = exp;
  endtask

  task automatic test_checksum_basic();
    mem[4] = 32'd1; mem[5] = 32'd2; mem[6] = 32'd3; mem[7] = 32'd4;
    run_sum(4, 4, 1'b0, 1'b0);
    total++;
    if (checksum !== 32'd10) begin bad++; $display("FAIL basic_10 got=%h exp=0000000a", checksum); end
  endtask

  task automatic test_wrap_overflow();
    mem[254] = 32'hFFFFFFFF; mem[255] = 32'd2; mem[0] = 32'd3;
    run_sum(254, 3, 1'b0, 1'b0);
    total++;
    if (checksum !== 32'd4) begin bad++; $display("FAIL wrap_4 got=%h exp=00000004", checksum); end
  endtask

  task automatic test_edges();
    run_sum(17, 0, 1'b0, 1'b0);
    run_sum(9, 12, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFFFFFF;
    run_sum(77, 256, 1'b0, 1'b0);
    total++;
    if (checksum !== 32'hFFFFFF00) begin bad++; $display("FAIL full_mem got=%h exp=ffffff00", checksum); end
  endtask

  task automatic test_random_sums();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < 5; k++) run_sum($urandom_range(0, 255), $urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_sum();
    sum_base = 8'd3;
    sum_len = 9'd100;
    sum_start = 1'b1;
    tick();
    sum_start = 1'b0;
    for (int c = 1; c < 50; c++) tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur = 0;
    total++;
    if (busy !== 1'b0 || checksum !== 32'd0) begin bad++; $display("FAIL mid_reset busy=%b checksum=%h exp=0/0", busy, checksum); end
    check_view("mid_reset");
    for (int c = 0; c < 110; c++) begin
      tick();
      total++;
      if (sum_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL no_done c=%0d done=%b busy=%b exp=0/0", c, sum_done, busy); end
    end
    pulse(1'b1);
  endtask

  task automatic test_back_to_back();
    run_sum(200, 7, 1'b0, 1'b0);
    run_sum(201, 1, 1'b0, 1'b0);
    total++;
    if (checksum !== mem[201]) begin bad++; $display("FAIL single_word got=%h exp=%h", checksum, mem[201]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cur = 0;
    rst = 1'b1;
    inc = 1'b0;
    dec = 1'b0;
    sum_start = 1'b0;
    sum_base = 8'd0;
    sum_len = 9'd0;
    test_reset();
    test_cursor_wrap();
    test_cursor_random();
    test_checksum_basic();
    test_wrap_overflow();
    test_edges();
    test_random_sums();
    test_back_to_back();
    test_reset_mid_sum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
